ws2812_chain_tx: RTL and testbench

Downstream stage for the I2C register map's colour bytes. It serialises a frame of NUM_PIXELS 24-bit RGB values onto one WS2812B data line, then holds the line low for the latch/reset gap. Pixels are pulled from upstream, either the I2C register file or a pixel RAM, through a valid/ready handshake with an index output. A one-pixel holding register lets back-to-back pixels go out with no inter-pixel gap.

---
 rtl/ws2812_pkg.sv | 37 +++
 rtl/ws2812_bit_timer.sv | 64 ++++++
 rtl/ws2812_chain_tx.sv | 148 ++++++++++++++
 tb/tb_ws2812_chain_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types, default 12 MHz timing and helpers for the WS2812B chain transmitter.
// Counter widths are derived from the timing parameters via width_for().
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_LATCH
  } state_e;

  typedef enum logic {
    ORDER_GRB,
    ORDER_RGB
  } color_order_e;

  localparam int DEF_NUM_PIXELS = 8;
  localparam int DEF_T0H        = 5;
  localparam int DEF_T1H        = 10;
  localparam int DEF_TBIT       = 15;
  localparam int DEF_TRES       = 3600;
  localparam int DEF_STALL_MAX  = 48;

  localparam color_order_e COLOR_ORDER = ORDER_GRB;

  // Bits needed for a counter that runs 0..n-1.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Packs a pixel into wire order, most significant bit sent first.
  function automatic logic [23:0] pack_pixel(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
    return (COLOR_ORDER == ORDER_GRB) ? {g, r, b} : {r, g, b};
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Times one WS2812B bit: line high for T0H/T1H cycles, low for the rest of TBIT.
// bit_done marks the last cycle of a bit; a start on that cycle chains the next bit gap-free.
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H,
  parameter int TBIT = DEF_TBIT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic sig_out,
  output logic bit_done
);

  localparam int CW = width_for(TBIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          val_q, val_d;
  logic          active_q, active_d;
  logic          sig_q, sig_d;

  assign bit_done = active_q && (cnt_q == CW'(TBIT - 1));
  assign sig_out  = sig_q;

  always_comb begin
    cnt_d    = cnt_q;
    val_d    = val_q;
    active_d = active_q;
    sig_d    = sig_q;
    if (start) begin
      cnt_d    = '0;
      val_d    = bit_val;
      active_d = 1'b1;
      sig_d    = 1'b1;
    end else if (active_q) begin
      if (bit_done) begin
        cnt_d    = '0;
        active_d = 1'b0;
        sig_d    = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        sig_d = (int'(cnt_d) < (val_q ? T1H : T0H));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      val_q    <= 1'b0;
      active_q <= 1'b0;
      sig_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      active_q <= active_d;
      sig_q    <= sig_d;
    end
  end

endmodule

// File: rtl/ws2812_chain_tx.sv
// Frame sequencer for a WS2812B chain: pulls pixels through a one-deep holding register,
// shifts them out GRB MSB-first, then holds the line low for the latch gap.
module ws2812_chain_tx
  import ws2812_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int T0H        = DEF_T0H,
  parameter int T1H        = DEF_T1H,
  parameter int TBIT       = DEF_TBIT,
  parameter int TRES       = DEF_TRES,
  parameter int STALL_MAX  = DEF_STALL_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_go,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] pix_idx,
  output logic       sig,
  output logic       busy,
  output logic       underrun
);

  localparam int SW = width_for(STALL_MAX);
  localparam int LW = width_for(TRES);

  state_e        state_q;
  logic          busy_q, underrun_q;
  logic [7:0]    pix_idx_q, acc_q, sent_q;
  logic [23:0]   hold_q, shift_q;
  logic          hold_full_q;
  logic [4:0]    bit_cnt_q;
  logic [SW-1:0] stall_q;
  logic [LW-1:0] latch_q;

  logic xfer, load, word_done, last_pix, bit_start, bit_val, bit_done;

  assign pix_ready = busy_q && !hold_full_q && (acc_q < 8'(NUM_PIXELS));
  assign xfer      = pix_valid && pix_ready;
  assign last_pix  = (sent_q == 8'(NUM_PIXELS - 1));
  assign word_done = (state_q == ST_SEND) && bit_done && (bit_cnt_q == 5'd23);
  // Loading from the holding register either starts a pixel or chains the next one.
  assign load      = hold_full_q && ((state_q == ST_FETCH) || (word_done && !last_pix));
  assign bit_start = load || ((state_q == ST_SEND) && bit_done && (bit_cnt_q != 5'd23));
  assign bit_val   = load ? hold_q[23] : shift_q[22];

  assign pix_idx  = pix_idx_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

  ws2812_bit_timer #(
    .T0H (T0H),
    .T1H (T1H),
    .TBIT(TBIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (bit_start),
    .bit_val (bit_val),
    .sig_out (sig),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      pix_idx_q   <= '0;
      acc_q       <= '0;
      sent_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stall_q     <= '0;
      latch_q     <= '0;
    end else begin
      if (xfer) begin
        hold_q <= pack_pixel(pix_r, pix_g, pix_b);
        acc_q  <= acc_q + 8'd1;
        if (pix_idx_q != 8'(NUM_PIXELS - 1)) pix_idx_q <= pix_idx_q + 8'd1;
      end
      hold_full_q <= (hold_full_q && !load) || xfer;

      if (load) begin
        shift_q   <= hold_q;
        bit_cnt_q <= '0;
      end else if (bit_start) begin
        shift_q   <= shift_q << 1;
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (frame_go) begin
            busy_q      <= 1'b1;
            underrun_q  <= 1'b0;
            pix_idx_q   <= '0;
            acc_q       <= '0;
            sent_q      <= '0;
            hold_full_q <= 1'b0;
            stall_q     <= '0;
            state_q     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (hold_full_q) begin
            state_q <= ST_SEND;
          end else if (stall_q == SW'(STALL_MAX - 1)) begin
            underrun_q <= 1'b1;
            latch_q    <= '0;
            state_q    <= ST_LATCH;
          end else begin
            stall_q <= stall_q + SW'(1);
          end
        end
        ST_SEND: begin
          if (word_done) begin
            if (last_pix) begin
              latch_q <= '0;
              state_q <= ST_LATCH;
            end else begin
              sent_q <= sent_q + 8'd1;
              if (!hold_full_q) begin
                stall_q <= '0;
                state_q <= ST_FETCH;
              end
            end
          end
        end
        ST_LATCH: begin
          if (latch_q == LW'(TRES - 1)) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            latch_q <= latch_q + LW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_chain_tx.sv
// Directed/randomised bench for ws2812_chain_tx: decodes the serial line back into pixels
// and checks timing, handshakes, stall/underrun handling and reset against a frame-level model.
module tb_ws2812_chain_tx;

  localparam int T0H       = 5;
  localparam int T1H       = 10;
  localparam int TBIT      = 15;
  localparam int TRES      = 3600;
  localparam int STALL_MAX = 48;
  localparam int PIX_CYC   = 24 * TBIT;
  localparam int BUDGET    = 8000;
  localparam int NEVER     = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       go8 = 1'b0, go1 = 1'b0, pix_valid = 1'b0;
  logic [7:0] pix_r = '0, pix_g = '0, pix_b = '0;
  logic       ready8, ready1, sig8, sig1, busy8, busy1, und8, und1;
  logic [7:0] idx8, idx1;

  ws2812_chain_tx #(.NUM_PIXELS(8), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRES(TRES),
                    .STALL_MAX(STALL_MAX)) dut8 (
    .clk(clk), .rst(rst), .frame_go(go8), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_valid(pix_valid), .pix_ready(ready8), .pix_idx(idx8), .sig(sig8), .busy(busy8),
    .underrun(und8));

  ws2812_chain_tx #(.NUM_PIXELS(1), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRES(TRES),
                    .STALL_MAX(STALL_MAX)) dut1 (
    .clk(clk), .rst(rst), .frame_go(go1), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_valid(pix_valid), .pix_ready(ready1), .pix_idx(idx1), .sig(sig1), .busy(busy1),
    .underrun(und1));

  int         checks = 0, errors = 0;
  string      cur_test = "reset";
  logic [7:0] mem_r[8], mem_g[8], mem_b[8];
  logic [7:0] pat[3];

  int         cyc, first_rise, hs_cnt, busy_cnt, bad_width, max_gap;
  logic [7:0] hs_idx[$];
  logic       dec_bits[$];
  bit         timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", cur_test, tag, obs, exp);
    end
  endtask

  // Runs one frame on the selected DUT, recording the decoded line and handshakes.
  // pix_valid is low for cycles [lo_s, lo_e); cycle 0 is the frame_go cycle.
  task automatic run_frame(input bit sel, input int lo_s, input int lo_e, input int g2,
                           input int g3, input int rst_at, input int und_at);
    int   hi = 0, lo = 0;
    logic prev = 1'b0, s, bz, rdy, und;
    logic [7:0] idx;
    dec_bits.delete();
    hs_idx.delete();
    first_rise = -1; hs_cnt = 0; busy_cnt = 0; bad_width = 0; max_gap = 0; timeout = 0;
    @(posedge clk); #1;
    for (cyc = 0; cyc <= BUDGET; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      s   = sel ? sig1 : sig8;
      bz  = sel ? busy1 : busy8;
      rdy = sel ? ready1 : ready8;
      idx = sel ? idx1 : idx8;
      und = sel ? und1 : und8;
      if (cyc == 0) chk("idle_busy", bz, 1'b0);
      if (cyc == 1) begin
        chk("go_busy", bz, 1'b1);
        chk("go_underrun_clear", und, 1'b0);
      end
      if (cyc == und_at) chk("underrun_before", und, 1'b0);
      if (und_at >= 0 && cyc == und_at + 1) chk("underrun_set", und, 1'b1);
      if (cyc == rst_at) begin
        chk("pre_rst_sig", s, 1'b1);
        rst = 1'b1;
      end
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        chk("rst_sig", s, 1'b0);
        chk("rst_busy", bz, 1'b0);
        chk("rst_ready", rdy, 1'b0);
        chk("rst_idx", idx, 8'd0);
        rst = 1'b0;
        go8 = 1'b0; go1 = 1'b0;
        return;
      end
      if (cyc > 0 && !bz) break;
      if (bz) busy_cnt++;
      if (s) begin
        if (!prev) begin
          if (first_rise < 0) first_rise = cyc;
          else if (lo > max_gap) max_gap = lo;
        end
        hi++;
        lo = 0;
      end else begin
        if (prev) begin
          dec_bits.push_back(hi >= 7);
          if (hi != T0H && hi != T1H) bad_width++;
          hi = 0;
        end
        lo++;
      end
      prev = s;
      go8 = !sel && (cyc == 0 || cyc == g2 || cyc == g3);
      go1 = sel && (cyc == 0 || cyc == g2 || cyc == g3);
      pix_valid = (cyc < lo_s) || (cyc >= lo_e);
      pix_r = mem_r[idx[2:0]];
      pix_g = mem_g[idx[2:0]];
      pix_b = mem_b[idx[2:0]];
      if (pix_valid && rdy) begin
        hs_cnt++;
        hs_idx.push_back(idx);
      end
    end
    go8 = 1'b0; go1 = 1'b0;
    timeout = (cyc > BUDGET);
  endtask

  // Compares the recorded frame against the expected pixels and frame timing.
  task automatic check_frame(input bit sel, input int npix, input int exp_busy,
                             input int exp_hs, input int gap_lo, input int gap_hi,
                             input logic exp_und);
    logic [23:0] w;
    chk("frame_done", timeout, 1'b0);
    chk("first_rise", first_rise, 3);
    chk("bit_count", dec_bits.size(), 24 * npix);
    for (int p = 0; p < npix; p++) begin
      w = '0;
      for (int k = 0; k < 24; k++)
        if (p * 24 + k < dec_bits.size()) w = {w[22:0], dec_bits[p*24+k]};
      chk($sformatf("pixel%0d_grb", p), w, {mem_g[p], mem_r[p], mem_b[p]});
    end
    chk("pulse_width", bad_width, 0);
    chk("handshakes", hs_cnt, exp_hs);
    for (int i = 0; i < hs_idx.size(); i++) chk($sformatf("hs_idx%0d", i), hs_idx[i], i);
    chk("busy_cycles", busy_cnt, exp_busy);
    chk("max_gap", (max_gap >= gap_lo) && (max_gap <= gap_hi), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after", sel ? busy1 : busy8, 1'b0);
    chk("underrun_after", sel ? und1 : und8, exp_und);
    $display("frame %s: %0d bits, %0d handshakes, %0d busy cycles, max gap %0d",
             cur_test, dec_bits.size(), hs_cnt, busy_cnt, max_gap);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 8; i++) begin
      mem_r[i] = 8'($urandom);
      mem_g[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
  endtask

  initial begin
    int tail;
    pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'h3C;
    randomize_mem();

    repeat (4) @(posedge clk);
    #1;
    chk("rst_sig8", sig8, 1'b0);   chk("rst_busy8", busy8, 1'b0);
    chk("rst_ready8", ready8, 1'b0); chk("rst_idx8", idx8, 8'd0);
    chk("rst_und8", und8, 1'b0);   chk("rst_sig1", sig1, 1'b0);
    chk("rst_busy1", busy1, 1'b0); chk("rst_ready1", ready1, 1'b0);
    rst = 1'b0;

    cur_test = "single_pixel";
    mem_r[0] = 8'h00; mem_g[0] = 8'hFF; mem_b[0] = 8'h00;
    run_frame(1'b1, NEVER, NEVER, -1, -1, -1, -1);
    check_frame(1'b1, 1, 2 + PIX_CYC + TRES, 1, 5, 10, 1'b0);

    cur_test = "eight_random";
    randomize_mem();
    run_frame(1'b0, NEVER, NEVER, -1, -1, -1, -1);
    check_frame(1'b0, 8, 2 + 8 * PIX_CYC + TRES, 8, 5, 10, 1'b0);

    cur_test = "pattern_ignored_go";
    for (int i = 0; i < 8; i++) begin
      mem_g[i] = pat[i % 3];
      mem_r[i] = pat[(i + 1) % 3];
      mem_b[i] = pat[(i + 2) % 3];
    end
    run_frame(1'b0, NEVER, NEVER, 200, 2 + 8 * PIX_CYC + 1000, -1, -1);
    check_frame(1'b0, 8, 2 + 8 * PIX_CYC + TRES, 8, 5, 10, 1'b0);

    // Pixel 2 ends on cycle 3+3*PIX_CYC-1; valid returns 20 cycles into the stall.
    cur_test = "stall20";
    randomize_mem();
    tail = mem_b[2][0] ? (TBIT - T1H) : (TBIT - T0H);
    run_frame(1'b0, 720, 3 + 3 * PIX_CYC + 20, -1, -1, -1, -1);
    check_frame(1'b0, 8, 2 + 8 * PIX_CYC + 22 + TRES, 8, tail + 22, tail + 22, 1'b0);

    cur_test = "stall_abort";
    randomize_mem();
    run_frame(1'b0, 720, NEVER, -1, -1, -1, 3 + 3 * PIX_CYC + STALL_MAX - 1);
    check_frame(1'b0, 3, 2 + 3 * PIX_CYC + STALL_MAX + TRES, 3, 5, 10, 1'b1);

    cur_test = "after_abort";
    randomize_mem();
    run_frame(1'b0, NEVER, NEVER, -1, -1, -1, -1);
    check_frame(1'b0, 8, 2 + 8 * PIX_CYC + TRES, 8, 5, 10, 1'b0);

    cur_test = "reset_mid_pixel2";
    run_frame(1'b0, NEVER, NEVER, -1, -1, 3 + 2 * PIX_CYC + 3, -1);
    $display("frame %s: reset applied at cycle %0d", cur_test, 3 + 2 * PIX_CYC + 3);

    cur_test = "after_reset";
    randomize_mem();
    run_frame(1'b0, NEVER, NEVER, -1, -1, -1, -1);
    check_frame(1'b0, 8, 2 + 8 * PIX_CYC + TRES, 8, 5, 10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
